// File: rtl/iccm_loader_pkg.sv
// rtl/iccm_loader_pkg.sv - shared types and constants for the ICCM UART boot loader
package iccm_loader_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    // UART receiver bit-level states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_W             = 16;

endpackage

// File: rtl/iccm_loader_uart_rx.sv
// rtl/iccm_loader_uart_rx.sv - 8N1 UART byte receiver with input synchroniser
module iccm_loader_uart_rx
    import iccm_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 182
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx_i,
    output logic       rx_dv_o,
    output logic [7:0] rx_byte_o
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             dv_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit FSM: confirm start at half bit, then sample each bit one period later
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dv_q    <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        dv_q    <= sync2_q;
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_dv_o   = dv_q;
    assign rx_byte_o = shift_q;

endmodule

// File: rtl/iccm_uart_loader.sv
// rtl/iccm_uart_loader.sv - UART boot-image parser writing ICCM words (option ICCM_LOADER_CHKSUM_EN)
module iccm_uart_loader
    import iccm_loader_pkg::*;
#(
    parameter int         ADDR_W       = 12,
    parameter int         DATA_W       = 32,
    parameter int         CLKS_PER_BIT = 182,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC  = 1_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_rx_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              reset_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int              BPW     = DATA_W / 8;
    localparam int              BI_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(BPW - 1);
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [63:0]     DEPTH   = 64'd1 << ADDR_W;

    logic              rx_dv;
    logic [7:0]        rx_byte;

    ld_state_e         state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [BI_W-1:0]   bidx_q;
    logic [DATA_W-1:0] word_q;
    logic [TO_W-1:0]   idle_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rst_q;
    logic              done_q;
    logic              err_q;
`ifdef ICCM_LOADER_CHKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic [LEN_W-1:0]  len_d;
    logic [DATA_W-1:0] word_full;
    logic              in_frame;
    logic              timeout_hit;

    iccm_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .uart_rx_i(uart_rx_i),
        .rx_dv_o  (rx_dv),
        .rx_byte_o(rx_byte)
    );

    // Length as it will be once the high byte lands; last byte completes the word on top
    always_comb begin
        len_d                    = {rx_byte, len_q[7:0]};
        word_full                = word_q;
        word_full[DATA_W-8 +: 8] = rx_byte;
        in_frame                 = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                                   (state_q == ST_DATA)   || (state_q == ST_CHK);
        timeout_hit              = in_frame && !rx_dv && (idle_q == TO_LAST);
    end

    // Inter-byte idle counter; restarts on each byte and each state change
    always_ff @(posedge clock) begin
        if (reset || !in_frame || rx_dv || timeout_hit) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 1'b1;
        end
    end

    // Frame FSM with registered ICCM write port and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rst_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ICCM_LOADER_CHKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (timeout_hit) begin
                state_q <= ST_ERR;
                rst_q   <= 1'b1;
                err_q   <= 1'b1;
            end else if (rx_dv) begin
                case (state_q)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state_q <= ST_LEN_LO;
                            rst_q   <= 1'b1;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
`ifdef ICCM_LOADER_CHKSUM_EN
                            sum_q   <= '0;
`endif
                        end
                    end
                    ST_LEN_LO: begin
                        len_q[7:0] <= rx_byte;
                        state_q    <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        len_q <= len_d;
                        if ({{(64-LEN_W){1'b0}}, len_d} > DEPTH) begin
                            state_q <= ST_ERR;
                            rst_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (len_d == '0) begin
`ifdef ICCM_LOADER_CHKSUM_EN
                            state_q <= ST_CHK;
`else
                            state_q <= ST_DONE;
                            rst_q   <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                            bidx_q  <= '0;
                        end
                    end
                    ST_DATA: begin
`ifdef ICCM_LOADER_CHKSUM_EN
                        sum_q <= sum_q + rx_byte;
`endif
                        if (bidx_q == BI_LAST) begin
                            we_q    <= 1'b1;
                            addr_q  <= ADDR_W'(idx_q);
                            wdata_q <= word_full;
                            bidx_q  <= '0;
                            idx_q   <= idx_q + 1'b1;
                            if (idx_q == len_q - 1'b1) begin
`ifdef ICCM_LOADER_CHKSUM_EN
                                state_q <= ST_CHK;
`else
                                state_q <= ST_DONE;
                                rst_q   <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end
                        end else begin
                            word_q[{bidx_q, 3'b000} +: 8] <= rx_byte;
                            bidx_q                        <= bidx_q + 1'b1;
                        end
                    end
`ifdef ICCM_LOADER_CHKSUM_EN
                    ST_CHK: begin
                        if (rx_byte == sum_q) begin
                            state_q <= ST_DONE;
                            rst_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            rst_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign reset_o = rst_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_iccm_uart_loader.sv
// tb/tb_iccm_uart_loader.sv - randomized frame-level checking of iccm_uart_loader
module tb_iccm_uart_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int CPB    = 4;
    localparam int TO     = 200;
    localparam int DEPTH  = 16;
    localparam int GAP    = 2 * CPB;
`ifdef ICCM_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx_i = 1'b1;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              reset_o;
    logic              done_o;
    logic              err_o;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    iccm_uart_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .uart_rx_i(uart_rx_i),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .reset_o  (reset_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next expected write, in order
    always @(negedge clock) begin
        if (we_o) begin
            obs_q.push_back('{int'(addr_o), wdata_o});
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: act=addr %0d data 0x%0h req=no write", addr_o, wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(addr_o), 64'(e.addr));
                check("write_data", 64'(wdata_o), 64'(e.data));
            end
        end
    end

    function automatic logic [7:0] sum8(input logic [31:0] w[$]);
        logic [7:0] s;
        s = 8'd0;
        foreach (w[i]) begin
            s += w[i][7:0];
            s += w[i][15:8];
            s += w[i][23:16];
            s += w[i][31:24];
        end
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            tick(CPB);
        end
        uart_rx_i = stop;
        tick(CPB);
        uart_rx_i = 1'b1;
        tick(GAP);
    endtask

    task automatic check_status(input string tag, input bit d, input bit e);
        check({tag, "_reset_o"}, 64'(reset_o), 64'(!d));
        check({tag, "_done_o"}, 64'(done_o), 64'(d));
        check({tag, "_err_o"}, 64'(err_o), 64'(e));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we_o"}, 64'(we_o), 64'd0);
        check({tag, "_addr_o"}, 64'(addr_o), 64'd0);
        check({tag, "_wdata_o"}, 64'(wdata_o), 64'd0);
        check_status(tag, 1'b0, 1'b0);
    endtask

    // Frame-level model: builds the byte stream, predicts writes and the final outcome
    task automatic do_frame(input logic [31:0] words[$], input int n, input bit corrupt, input int keep);
        logic [7:0] b[$];
        int         nsend;
        int         nw;
        bit         exp_done;
        b.push_back(8'hA5);
        b.push_back(n[7:0]);
        b.push_back(n[15:8]);
        if (n <= DEPTH) begin
            foreach (words[i])
                for (int k = 0; k < 4; k++) b.push_back(words[i][8*k +: 8]);
            if (CHK_EN) b.push_back(sum8(words) ^ {7'd0, corrupt});
        end
        nsend = (keep >= 0 && keep < b.size()) ? keep : b.size();
        nw = 0;
        if (n <= DEPTH && nsend > 3) nw = (nsend - 3) / 4;
        if (nw > n) nw = n;
        for (int i = 0; i < nw; i++) exp_q.push_back('{i, words[i]});
        exp_done = (n <= DEPTH) && (nsend == b.size()) && !(CHK_EN && corrupt);
        send_byte(b[0], 1'b1);
        check_status("after_sync", 1'b0, 1'b0);
        for (int i = 1; i < nsend; i++) send_byte(b[i], 1'b1);
        if (nsend < b.size()) tick(TO + 60);
        check_status("frame_end", exp_done, !exp_done);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] nom[$];
        logic [31:0] one[$];
        logic [31:0] none[$];
        logic [31:0] rnd[$];
        int          n;
        int          mode;

        nom = '{32'h11223344, 32'hDEADBEEF};
        one = '{32'h99887766};

        reset = 1'b1;
        tick(4);
        check_reset_vals("reset");
        reset = 1'b0;
        tick(4);

        check("model_sum_pin", 64'(sum8(nom)), 64'hE2);

        // Nominal load, pinned to literal writes
        obs_q.delete();
        do_frame(nom, 2, 1'b0, -1);
        check("nominal_write_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            check("nominal_addr0", 64'(obs_q[0].addr), 64'd0);
            check("nominal_data0", 64'(obs_q[0].data), 64'h11223344);
            check("nominal_addr1", 64'(obs_q[1].addr), 64'd1);
            check("nominal_data1", 64'(obs_q[1].data), 64'hDEADBEEF);
        end

        // Bad checksum, oversize, zero-length and full-depth boundary
        do_frame(nom, 2, 1'b1, -1);
        do_frame(none, 17, 1'b0, -1);
        do_frame(none, 0, 1'b0, -1);
        rnd.delete();
        for (int i = 0; i < DEPTH; i++) rnd.push_back($urandom);
        do_frame(rnd, DEPTH, 1'b0, -1);

        // Timeout mid-word, then recovery; timeout after one completed write
        do_frame(one, 1, 1'b0, 4);
        do_frame(nom, 2, 1'b0, -1);
        do_frame(nom, 2, 1'b0, 8);
        do_frame(nom, 2, 1'b0, -1);

        // Noise and a framing-error sync byte must not start a load
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b0);
        check_status("noise", 1'b1, 1'b0);
        obs_q.delete();
        do_frame(nom, 2, 1'b0, -1);
        check("noise_write_count", 64'(obs_q.size()), 64'd2);

        // Reset after the second data byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        reset = 1'b1;
        tick(2);
        check_reset_vals("midload_reset");
        reset = 1'b0;
        tick(4);
        do_frame(nom, 2, 1'b0, -1);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            mode = $urandom_range(0, 9);
            rnd.delete();
            if (mode == 0) begin
                n = $urandom_range(DEPTH + 1, DEPTH + 4);
                do_frame(rnd, n, 1'b0, -1);
            end else begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++) rnd.push_back($urandom);
                if (mode == 1)
                    do_frame(rnd, n, 1'b0, $urandom_range(1, 3 + 4 * n));
                else
                    do_frame(rnd, n, 1'($urandom_range(0, 1)), -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iccm_uart_loader.md
# iccm_uart_loader

Parametrised successor to the fixed UART programming path (byte receiver plus ICCM write controller) used to load instruction memory in the azadi SoC. It deserialises a UART bit stream, parses a framed boot image with length header, optional checksum and inter-byte timeout, and emits ICCM word writes. It holds the core in reset until a load completes successfully. It sits between the `uart_rx_i` pad and the ICCM write port / `rstmgr` `iccm_rst_i` input.

## Interface
- `ADDR_W`, 12: ICCM word-address width; depth = 2**ADDR_W words.
- `DATA_W`, 32: ICCM word width; multiple of 8, 8..64.
- `CLKS_PER_BIT`, 182: clock cycles per UART bit; must be ≥ 4.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYC`, 1_000_000: maximum idle cycles between bytes inside a frame.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `uart_rx_i` in 1: asynchronous serial input, idle high.
- `we_o` out 1: ICCM write strobe, one-cycle pulse.
- `addr_o` out ADDR_W: ICCM word address.
- `wdata_o` out DATA_W: ICCM write data.
- `reset_o` out 1: core hold; 1 = keep the system in reset.
- `done_o` out 1: last load succeeded.
- `err_o` out 1: last load aborted (length, checksum or timeout).

## Operation
- Reset values: `we_o`=0, `addr_o`=0, `wdata_o`=0, `reset_o`=1, `done_o`=0, `err_o`=0; FSM in IDLE.
- RX path: `uart_rx_i` passes through a 2-flop synchroniser. A falling edge starts reception. The start bit is confirmed low at CLKS_PER_BIT/2, otherwise the receiver returns to idle. 8 data bits are sampled LSB-first every CLKS_PER_BIT cycles, then the stop bit.
  - Stop bit 1: one-cycle `rx_dv` with the byte.
  - Stop bit 0: byte discarded silently.
- FSM states and transitions:
  - IDLE: any byte ≠ SYNC_BYTE is ignored. SYNC_BYTE → LEN_LO. On entry to LEN_LO: clear the sum, set `reset_o`=1, `done_o`=0, `err_o`=0.
  - LEN_LO → LEN_HI: latches the 16-bit word count N, little-endian.
  - At LEN_HI:
    - N > 2**ADDR_W → ERR.
    - N = 0 → CHK (or DONE when the checksum is compiled out).
    - Otherwise → DATA, with word index 0.
  - DATA: collects DATA_W/8 bytes per word, little-endian; each byte is added to an 8-bit sum (mod 256). On the last byte of a word: pulse `we_o`, `addr_o`=index, `wdata_o`=assembled word, then increment the index. After word N-1 → CHK.
  - CHK: the received byte equal to the sum → DONE; otherwise → ERR.
  - DONE: `reset_o`=0, `done_o`=1.
  - ERR: `reset_o`=1, `err_o`=1.
  - From DONE or ERR, a SYNC_BYTE restarts via LEN_LO; other bytes are ignored.
- Timeout: an idle counter clears on every `rx_dv` and on every state change. In LEN_LO, LEN_HI, DATA or CHK, reaching TIMEOUT_CYC → ERR. Writes already issued are not retracted.
- SYNC_BYTE inside a frame is treated as data, not as a restart.
- `reset` mid-load: all outputs return to reset values immediately; the partial image stays in ICCM.

## Timing
- `rx_dv` fires at the stop-bit midpoint: start edge + 2 sync cycles + 9.5·CLKS_PER_BIT.
- `we_o` asserts the cycle after the `rx_dv` of a word's final byte. `addr_o` and `wdata_o` are stable that cycle and hold until the next write.
- `reset_o`, `done_o` and `err_o` update the cycle after the deciding byte's `rx_dv`, or the cycle after the timeout count is reached.
- At most one write per 10·CLKS_PER_BIT·DATA_W/8 cycles; no backpressure, since ICCM accepts every write.

## Configuration
- `ICCM_LOADER_CHKSUM_EN` defined:
  - the CHK state and the sum register exist;
  - the frame ends with the checksum byte.
- Undefined:
  - no checksum byte is expected;
  - the last data word (or N = 0 at LEN_HI) → DONE directly;
  - ERR is reachable only via length or timeout.

## Structure
- Package `iccm_loader_pkg`:
  - FSM state enum: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR;
  - RX state enum;
  - default SYNC_BYTE constant;
  - length width constant (16).
- Sub-module `iccm_loader_uart_rx`, parameter CLKS_PER_BIT: contains the synchroniser and bit FSM; outputs `rx_dv` and `rx_byte`.
- The top holds the frame FSM, word assembler, checksum and timeout counter.

## Test plan
All cases use CLKS_PER_BIT=4 and TIMEOUT_CYC=200.
- Nominal load: send A5 02 00 44 33 22 11 EF BE AD DE E2 → writes (0,0x11223344), (1,0xDEADBEEF); then `reset_o`=0, `done_o`=1.
- Bad checksum: same frame with final byte E3 → both writes occur; `err_o`=1, `reset_o`=1.
- Oversize length: ADDR_W=4, send A5 11 00 → ERR after LEN_HI; no `we_o`.
- Timeout: send A5 01 00 44, then idle for 200 cycles → `err_o`=1; then the full valid frame → `done_o`=1, `err_o`=0.
- Noise and framing error: send bytes 00 FF, a byte with stop bit 0 carrying A5, then the valid frame → exactly one load, `done_o`=1.
- Reset mid-load: assert `reset` after the second data byte → all outputs return to reset values; a subsequent valid frame loads normally.
